ami_r_arb: RTL and testbench

- Shares one AXI read master port (AR/R) among N requesters, all in the ACLK domain.
- Typically sits between N read clients and a single AXI master read interface or the read-side clock-crossing buffer.
- AR requests are granted round-robin and tagged by prepending the requester index to ARID.
- R beats are routed back by decoding the RID tag.
- A global outstanding-burst limit throttles new grants.

---
 rtl/ami_r_arb.sv | 237 +++++++++++++++++++++++
 tb/tb_ami_r_arb.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ami_r_arb.sv
// ami_r_arb: N-to-1 AXI read arbiter. AR requests are granted round-robin and
// tagged with the requester index in the upper ARID bits. R beats are routed back
// by decoding that tag. A global limit caps the number of outstanding bursts.
// Optional build macro AMI_RARB_FIXPRIO_EN: fixed priority, lowest index wins.
module ami_r_arb #(
  parameter int unsigned N      = 4,
  parameter int unsigned AXI_DW = 128,
  parameter int unsigned AXI_AW = 32,
  parameter int unsigned AXI_IW = 8,
  parameter int unsigned AXI_LW = 8,
  parameter int unsigned AXI_SW = 3,
  parameter int unsigned OST_D  = 4,
  parameter int unsigned IXW    = $clog2(N),
  parameter int unsigned UIW    = AXI_IW - IXW,
  parameter int unsigned OCW    = $clog2(OST_D + 1)
) (
  input  logic                ACLK,
  input  logic                ARESETn,
  input  logic [N*UIW-1:0]    s_arid,
  input  logic [N*AXI_AW-1:0] s_araddr,
  input  logic [N*AXI_LW-1:0] s_arlen,
  input  logic [N*AXI_SW-1:0] s_arsize,
  input  logic [N*2-1:0]      s_arburst,
  input  logic [N-1:0]        s_arvalid,
  output logic [N-1:0]        s_arready,
  output logic [N*UIW-1:0]    s_rid,
  output logic [N*AXI_DW-1:0] s_rdata,
  output logic [N*2-1:0]      s_rresp,
  output logic [N-1:0]        s_rlast,
  output logic [N-1:0]        s_rvalid,
  input  logic [N-1:0]        s_rready,
  output logic [AXI_IW-1:0]   ARID,
  output logic [AXI_AW-1:0]   ARADDR,
  output logic [AXI_LW-1:0]   ARLEN,
  output logic [AXI_SW-1:0]   ARSIZE,
  output logic [1:0]          ARBURST,
  output logic                ARVALID,
  input  logic                ARREADY,
  input  logic [AXI_IW-1:0]   RID,
  input  logic [AXI_DW-1:0]   RDATA,
  input  logic [1:0]          RRESP,
  input  logic                RLAST,
  input  logic                RVALID,
  output logic                RREADY,
  output logic [OCW-1:0]      ost_cnt,
  output logic                tag_err
);

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  state_e              state_q, state_d;
  logic                arvalid_q, arvalid_d;
  logic [AXI_IW-1:0]   arid_q;
  logic [AXI_AW-1:0]   araddr_q;
  logic [AXI_LW-1:0]   arlen_q;
  logic [AXI_SW-1:0]   arsize_q;
  logic [1:0]          arburst_q;
  logic [OCW-1:0]      ost_cnt_q, ost_cnt_d;
  logic                tag_err_q, tag_err_d;

  logic                win_found;
  logic [IXW-1:0]      win;
  logic                grant;
  logic [UIW-1:0]      sel_arid;
  logic [AXI_AW-1:0]   sel_araddr;
  logic [AXI_LW-1:0]   sel_arlen;
  logic [AXI_SW-1:0]   sel_arsize;
  logic [1:0]          sel_arburst;

  logic [IXW-1:0]      r_tag;
  logic                tag_ok;
  logic                rready_sel;
  logic                rlast_hs;

`ifndef AMI_RARB_FIXPRIO_EN
  logic [IXW-1:0]      rr_last_q;

  // Round-robin pointer: remembers the last winner.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) rr_last_q <= IXW'(N - 1);
    else if (grant) rr_last_q <= win;
  end
`endif

  // Winner selection.
  always_comb begin
    win_found = 1'b0;
    win       = '0;
`ifdef AMI_RARB_FIXPRIO_EN
    for (int i = 0; i < N; i++) begin
      if (!win_found && s_arvalid[i]) begin
        win_found = 1'b1;
        win       = IXW'(i);
      end
    end
`else
    // First pass covers indices above the last winner, second pass wraps around.
    for (int i = 0; i < N; i++) begin
      if (!win_found && s_arvalid[i] && (IXW'(i) > rr_last_q)) begin
        win_found = 1'b1;
        win       = IXW'(i);
      end
    end
    for (int i = 0; i < N; i++) begin
      if (!win_found && s_arvalid[i] && (IXW'(i) <= rr_last_q)) begin
        win_found = 1'b1;
        win       = IXW'(i);
      end
    end
`endif
  end

  assign grant = (state_q == StIdle) && win_found && (ost_cnt_q < OCW'(OST_D));

  // One-hot grant pulse and payload mux for the winner.
  always_comb begin
    s_arready   = '0;
    sel_arid    = '0;
    sel_araddr  = '0;
    sel_arlen   = '0;
    sel_arsize  = '0;
    sel_arburst = '0;
    for (int i = 0; i < N; i++) begin
      if (win == IXW'(i)) begin
        s_arready[i] = grant;
        sel_arid     = s_arid[i*UIW +: UIW];
        sel_araddr   = s_araddr[i*AXI_AW +: AXI_AW];
        sel_arlen    = s_arlen[i*AXI_LW +: AXI_LW];
        sel_arsize   = s_arsize[i*AXI_SW +: AXI_SW];
        sel_arburst  = s_arburst[i*2 +: 2];
      end
    end
  end

  // AR FSM next state.
  always_comb begin
    state_d   = state_q;
    arvalid_d = arvalid_q;
    unique case (state_q)
      StIdle: begin
        if (grant) begin
          state_d   = StBusy;
          arvalid_d = 1'b1;
        end
      end
      StBusy: begin
        if (ARREADY) begin
          state_d   = StIdle;
          arvalid_d = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // AR FSM state and registered AR channel.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q   <= StIdle;
      arvalid_q <= 1'b0;
      arid_q    <= '0;
      araddr_q  <= '0;
      arlen_q   <= '0;
      arsize_q  <= '0;
      arburst_q <= '0;
    end else begin
      state_q   <= state_d;
      arvalid_q <= arvalid_d;
      if (grant) begin
        arid_q    <= {win, sel_arid};
        araddr_q  <= sel_araddr;
        arlen_q   <= sel_arlen;
        arsize_q  <= sel_arsize;
        arburst_q <= sel_arburst;
      end
    end
  end

  assign ARID    = arid_q;
  assign ARADDR  = araddr_q;
  assign ARLEN   = arlen_q;
  assign ARSIZE  = arsize_q;
  assign ARBURST = arburst_q;
  assign ARVALID = arvalid_q;

  // R routing: decode the tag, unknown tags are accepted and dropped.
  assign r_tag = RID[AXI_IW-1:UIW];

  always_comb begin
    tag_ok     = 1'b0;
    rready_sel = 1'b0;
    s_rvalid   = '0;
    for (int i = 0; i < N; i++) begin
      if (r_tag == IXW'(i)) begin
        tag_ok      = 1'b1;
        rready_sel  = s_rready[i];
        s_rvalid[i] = RVALID;
      end
    end
    RREADY = tag_ok ? rready_sel : 1'b1;
  end

  assign s_rid   = {N{RID[UIW-1:0]}};
  assign s_rdata = {N{RDATA}};
  assign s_rresp = {N{RRESP}};
  assign s_rlast = {N{RLAST}};

  assign rlast_hs = RVALID && RREADY && RLAST;

  // Outstanding counter and sticky error flag next state.
  always_comb begin
    ost_cnt_d = ost_cnt_q;
    tag_err_d = tag_err_q;
    if (RVALID && !tag_ok) tag_err_d = 1'b1;
    if (grant && !rlast_hs) begin
      ost_cnt_d = ost_cnt_q + OCW'(1);
    end else if (rlast_hs && !grant) begin
      if (ost_cnt_q == '0) tag_err_d = 1'b1;
      else ost_cnt_d = ost_cnt_q - OCW'(1);
    end
  end

  // Counter and flag registers.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      ost_cnt_q <= '0;
      tag_err_q <= 1'b0;
    end else begin
      ost_cnt_q <= ost_cnt_d;
      tag_err_q <= tag_err_d;
    end
  end

  assign ost_cnt = ost_cnt_q;
  assign tag_err = tag_err_q;

endmodule

// File: tb/tb_ami_r_arb.sv
// Directed bench for ami_r_arb: main instance N=4, second instance N=3 for tag errors.
module tb_ami_r_arb;

  logic         ACLK = 1'b0;
  logic         ARESETn;

  // N=4 instance signals
  logic [23:0]  s_arid;
  logic [127:0] s_araddr;
  logic [31:0]  s_arlen;
  logic [11:0]  s_arsize;
  logic [7:0]   s_arburst;
  logic [3:0]   s_arvalid, s_arready;
  logic [23:0]  s_rid;
  logic [511:0] s_rdata;
  logic [7:0]   s_rresp;
  logic [3:0]   s_rlast, s_rvalid, s_rready;
  logic [7:0]   ARID;
  logic [31:0]  ARADDR;
  logic [7:0]   ARLEN;
  logic [2:0]   ARSIZE;
  logic [1:0]   ARBURST;
  logic         ARVALID, ARREADY;
  logic [7:0]   RID;
  logic [127:0] RDATA;
  logic [1:0]   RRESP;
  logic         RLAST, RVALID, RREADY;
  logic [2:0]   ost_cnt;
  logic         tag_err;

  // N=3 instance signals
  logic [17:0]  n3_s_arid;
  logic [95:0]  n3_s_araddr;
  logic [23:0]  n3_s_arlen;
  logic [8:0]   n3_s_arsize;
  logic [5:0]   n3_s_arburst;
  logic [2:0]   n3_s_arvalid, n3_s_arready;
  logic [17:0]  n3_s_rid;
  logic [383:0] n3_s_rdata;
  logic [5:0]   n3_s_rresp;
  logic [2:0]   n3_s_rlast, n3_s_rvalid, n3_s_rready;
  logic [7:0]   n3_ARID;
  logic [31:0]  n3_ARADDR;
  logic [7:0]   n3_ARLEN;
  logic [2:0]   n3_ARSIZE;
  logic [1:0]   n3_ARBURST;
  logic         n3_ARVALID;
  logic [7:0]   n3_RID;
  logic         n3_RVALID, n3_RREADY;
  logic [2:0]   n3_ost_cnt;
  logic         n3_tag_err;

  typedef struct packed {
    logic [7:0]  id;
    logic [31:0] addr;
    logic [7:0]  len;
  } ar_t;

  ar_t exp_q[$];
  ar_t mon_e;
  int  n_checks = 0;
  int  n_errors = 0;
  int  n_hs     = 0;

  always #5 ACLK = ~ACLK;

  ami_r_arb #(.N(4)) u_dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .s_arid(s_arid), .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arsize(s_arsize),
    .s_arburst(s_arburst), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rid(s_rid), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast),
    .s_rvalid(s_rvalid), .s_rready(s_rready),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
    .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID),
    .RREADY(RREADY), .ost_cnt(ost_cnt), .tag_err(tag_err)
  );

  ami_r_arb #(.N(3)) u_dut3 (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .s_arid(n3_s_arid), .s_araddr(n3_s_araddr), .s_arlen(n3_s_arlen),
    .s_arsize(n3_s_arsize), .s_arburst(n3_s_arburst), .s_arvalid(n3_s_arvalid),
    .s_arready(n3_s_arready), .s_rid(n3_s_rid), .s_rdata(n3_s_rdata),
    .s_rresp(n3_s_rresp), .s_rlast(n3_s_rlast), .s_rvalid(n3_s_rvalid),
    .s_rready(n3_s_rready),
    .ARID(n3_ARID), .ARADDR(n3_ARADDR), .ARLEN(n3_ARLEN), .ARSIZE(n3_ARSIZE),
    .ARBURST(n3_ARBURST), .ARVALID(n3_ARVALID), .ARREADY(ARREADY),
    .RID(n3_RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(n3_RVALID),
    .RREADY(n3_RREADY), .ost_cnt(n3_ost_cnt), .tag_err(n3_tag_err)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Expected AR issue for requester w, built from the payload currently driven.
  task automatic push_exp(input int w);
    ar_t e;
    e.id   = {2'(w), s_arid[w*6 +: 6]};
    e.addr = s_araddr[w*32 +: 32];
    e.len  = s_arlen[w*8 +: 8];
    exp_q.push_back(e);
  endtask

  task automatic wait_hs(input int target, input string tag);
    int c = 0;
    while (n_hs < target && c < 40) begin
      @(negedge ACLK);
      c++;
    end
    chk(tag, n_hs, target);
  endtask

  task automatic r_beat(input logic [7:0] id, input logic last, input logic [3:0] rdy);
    @(negedge ACLK);
    RID = id; RLAST = last; s_rready = rdy; RVALID = 1'b1;
    @(negedge ACLK);
    RVALID = 1'b0; RLAST = 1'b0;
  endtask

  // Scoreboard side: every AR handshake is popped and compared.
  always @(posedge ACLK) begin
    if (ARESETn && ARVALID && ARREADY) begin
      n_hs++;
      n_checks++;
      assert (exp_q.size() > 0) else begin
        n_errors++;
        $error("FAIL ar_unexpected: got ARID %0h want no issue", ARID);
      end
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        chk("arid", ARID, mon_e.id);
        chk("araddr", ARADDR, mon_e.addr);
        chk("arlen", ARLEN, mon_e.len);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1, "timeout");
  end

  initial begin
    ARESETn = 1'b0;
    s_arvalid = '0; s_rready = '0; ARREADY = 1'b0;
    RID = '0; RDATA = '0; RRESP = '0; RLAST = 1'b0; RVALID = 1'b0;
    n3_s_arid = '0; n3_s_araddr = '0; n3_s_arlen = '0; n3_s_arsize = '0;
    n3_s_arburst = '0; n3_s_arvalid = '0; n3_s_rready = '0;
    n3_RID = '0; n3_RVALID = 1'b0;
    for (int i = 0; i < 4; i++) begin
      s_arid[i*6 +: 6]    = 6'(i + 1);
      s_araddr[i*32 +: 32] = 32'h1000 * (i + 1);
      s_arlen[i*8 +: 8]   = 8'(i + 3);
      s_arsize[i*3 +: 3]  = 3'd4;
      s_arburst[i*2 +: 2] = 2'b01;
    end
    repeat (2) @(negedge ACLK);
    ARESETn = 1'b1;
    #1;
    chk("rst_arvalid", ARVALID, 1'b0);
    chk("rst_araddr", ARADDR, 32'h0);
    chk("rst_arid", ARID, 8'h0);
    chk("rst_ost", ost_cnt, 3'd0);
    chk("rst_tag_err", tag_err, 1'b0);
    chk("rst_n3_tag_err", n3_tag_err, 1'b0);

    // All four requesting: grants until the outstanding limit is reached.
    @(negedge ACLK);
    ARREADY = 1'b1;
    s_arvalid = 4'hf;
`ifdef AMI_RARB_FIXPRIO_EN
    for (int k = 0; k < 4; k++) push_exp(0);
`else
    for (int k = 0; k < 4; k++) push_exp(k);
`endif
    #1 chk("t1_first_grant", s_arready, 4'b0001);
    wait_hs(4, "t1_hs_count");
    @(negedge ACLK);
    #1;
    chk("t1_ost_full", ost_cnt, 3'd4);
    chk("t1_throttled", s_arready, 4'b0000);
    chk("t1_arvalid_low", ARVALID, 1'b0);
    chk("t1_sb_empty", exp_q.size(), 0);
    s_arvalid = 4'h0;

    // Throttle release: requester 0 waits until a last beat frees a slot.
    @(negedge ACLK);
    s_arid[0 +: 6] = 6'h2a;
    s_arvalid = 4'b0001;
    #1 chk("t4_throttle", s_arready, 4'b0000);
    @(negedge ACLK);
    RID = 8'h2a; RLAST = 1'b1; s_rready = 4'b0001; RVALID = 1'b1;
    push_exp(0);
    #1;
    chk("t4_rready", RREADY, 1'b1);
    chk("t4_rvalid", s_rvalid, 4'b0001);
    chk("t4_still_throttled", s_arready, 4'b0000);
    @(negedge ACLK);
    RVALID = 1'b0; RLAST = 1'b0;
    #1;
    chk("t4_ost_dec", ost_cnt, 3'd3);
    chk("t4_grant", s_arready, 4'b0001);
    @(negedge ACLK);
    chk("t4_ost_back", ost_cnt, 3'd4);
    chk("t4_arvalid", ARVALID, 1'b1);
    chk("t4_busy_noready", s_arready, 4'b0000);
    s_arvalid = 4'h0;
    @(negedge ACLK);
    chk("t4_sb_empty", exp_q.size(), 0);

    // R routing by tag, ready follows the addressed requester combinationally.
    @(negedge ACLK);
    RID = 8'h83; RDATA = 128'hfeed_0123_4567_89ab_cdef_0011_2233_4455;
    RRESP = 2'b10; RLAST = 1'b0; s_rready = 4'b0000; RVALID = 1'b1;
    #1;
    chk("t3_rvalid", s_rvalid, 4'b0100);
    chk("t3_rid", s_rid[12 +: 6], 6'h03);
    chk("t3_rready_low", RREADY, 1'b0);
    chk("t3_rdata", s_rdata[128 +: 128], 128'hfeed_0123_4567_89ab_cdef_0011_2233_4455);
    chk("t3_rresp", s_rresp[6 +: 2], 2'b10);
    s_rready = 4'b0100;
    #1 chk("t3_rready_high", RREADY, 1'b1);
    @(negedge ACLK);
    RVALID = 1'b0;
    chk("t3_ost_nolast", ost_cnt, 3'd4);

    // Drain all four outstanding bursts.
    for (int k = 0; k < 4; k++) begin
      r_beat({2'(k), 6'h01}, 1'b1, 4'hf);
      chk($sformatf("drain_ost%0d", k), ost_cnt, 3'(3 - k));
    end
    chk("drain_tag_err", tag_err, 1'b0);

    // Requester 2 held off by ARREADY low: AR channel must stay stable.
    @(negedge ACLK);
    ARREADY = 1'b0;
    s_arid[12 +: 6] = 6'h15;
    s_arvalid = 4'b0100;
    push_exp(2);
    #1 chk("t2_grant", s_arready, 4'b0100);
    for (int c = 0; c < 5; c++) begin
      @(negedge ACLK);
      chk($sformatf("t2_arvalid%0d", c), ARVALID, 1'b1);
      chk($sformatf("t2_arid%0d", c), ARID, 8'h95);
      chk($sformatf("t2_noready%0d", c), s_arready, 4'b0000);
    end
    ARREADY = 1'b1;
    s_arvalid = 4'h0;
    @(negedge ACLK);
    chk("t2_arvalid_drop", ARVALID, 1'b0);
    s_arvalid = 4'b0010;
    push_exp(1);
    #1 chk("t2_idle_after", s_arready, 4'b0010);
    @(negedge ACLK);
    s_arvalid = 4'h0;
    @(negedge ACLK);
    chk("t2_sb_empty", exp_q.size(), 0);
    chk("t2_ost", ost_cnt, 3'd2);

    // Underflow: one more last beat than outstanding bursts.
    r_beat(8'h01, 1'b1, 4'hf);
    r_beat(8'h41, 1'b1, 4'hf);
    chk("uf_ost_zero", ost_cnt, 3'd0);
    chk("uf_tag_err_clear", tag_err, 1'b0);
    r_beat(8'h81, 1'b1, 4'hf);
    chk("uf_ost_sat", ost_cnt, 3'd0);
    chk("uf_tag_err", tag_err, 1'b1);

    // Reset clears the sticky flag, then requesters 0 and 3 compete.
    @(negedge ACLK);
    ARESETn = 1'b0;
    #1 chk("rst2_tag_err", tag_err, 1'b0);
    @(negedge ACLK);
    ARESETn = 1'b1;
    n_hs = 0;
    s_arvalid = 4'b1001;
`ifdef AMI_RARB_FIXPRIO_EN
    for (int k = 0; k < 4; k++) push_exp(0);
`else
    push_exp(0); push_exp(3); push_exp(0); push_exp(3);
`endif
    wait_hs(4, "t5_hs_count");
    s_arvalid = 4'h0;
    @(negedge ACLK);
    chk("t5_sb_empty", exp_q.size(), 0);
    chk("t5_ost", ost_cnt, 3'd4);

    // N=3 instance: tag 3 is invalid, beat dropped and flag set.
    @(negedge ACLK);
    n3_RID = 8'hc5; n3_RVALID = 1'b1; n3_s_rready = 3'b000;
    #1;
    chk("n3_bad_rready", n3_RREADY, 1'b1);
    chk("n3_bad_rvalid", n3_s_rvalid, 3'b000);
    @(negedge ACLK);
    n3_RVALID = 1'b0;
    chk("n3_tag_err", n3_tag_err, 1'b1);
    n3_RID = 8'h85; n3_RVALID = 1'b1; n3_s_rready = 3'b100;
    #1;
    chk("n3_good_rvalid", n3_s_rvalid, 3'b100);
    chk("n3_good_rid", n3_s_rid[12 +: 6], 6'h05);
    chk("n3_good_rready", n3_RREADY, 1'b1);
    @(negedge ACLK);
    n3_RVALID = 1'b0;
    repeat (3) @(negedge ACLK);
    chk("n3_tag_err_sticky", n3_tag_err, 1'b1);
    chk("n3_ost", n3_ost_cnt, 3'd0);
    ARESETn = 1'b0;
    #1;
    chk("n3_rst_tag_err", n3_tag_err, 1'b0);
    chk("rst3_ost", ost_cnt, 3'd0);
    chk("rst3_arvalid", ARVALID, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
